hpdcache_sram_wbyteenable_banked_1rw: RTL and testbench

//  Banked single-port SRAM with byte-enable writes, valid/ready request port and self-initialisation.

---
 rtl/hpdcache_sram_wbyteenable_banked_1rw.sv | 172 +++++++++++++++++
 tb/tb_hpdcache_sram_wbyteenable_banked_1rw.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_sram_wbyteenable_banked_1rw.sv
// rtl/hpdcache_sram_wbyteenable_banked_1rw.sv - banked 1RW SRAM with byte-enable writes and self-initialisation
// Optional feature macro: HPDCACHE_SRAM_OUTREG_EN (extra read output register stage, read latency 2)
module hpdcache_sram_wbyteenable_banked_1rw #(
  parameter int unsigned          ADDR_SIZE  = 6,
  parameter int unsigned          DATA_SIZE  = 64,
  parameter int unsigned          NBANKS     = 4,
  parameter logic [DATA_SIZE-1:0] INIT_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reinit_i,
  output logic                   init_done_o,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [ADDR_SIZE-1:0]   req_addr_i,
  input  logic [DATA_SIZE-1:0]   req_wdata_i,
  input  logic [DATA_SIZE/8-1:0] req_wbe_i,
  output logic                   rsp_valid_o,
  output logic [DATA_SIZE-1:0]   rsp_rdata_o
);

  localparam int unsigned DEPTH  = 2 ** ADDR_SIZE;
  localparam int unsigned ROWS   = DEPTH / NBANKS;
  localparam int unsigned LOG2NB = $clog2(NBANKS);
  localparam int unsigned BANK_W = (NBANKS > 1) ? LOG2NB : 1;
  localparam int unsigned ROW_W  = (ROWS > 1) ? (ADDR_SIZE - LOG2NB) : 1;
  localparam int unsigned NBYTES = DATA_SIZE / 8;

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   cnt_q, cnt_d;
  logic               init_done_q, init_done_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [BANK_W-1:0]    bank_idx;
  logic [ROW_W-1:0]     row_idx;
  logic                 req_acc, wr_acc, rd_acc, in_init;
  logic [ROW_W-1:0]     mem_row;
  logic [DATA_SIZE-1:0] mem_wdata;
  logic [NBYTES-1:0]    mem_wbe;
  logic [DATA_SIZE-1:0] bank_rdata [NBANKS];
  logic [DATA_SIZE-1:0] rd_word;

  // Low address bits pick the bank, the remaining bits pick the row inside it
  if (NBANKS > 1) begin : g_bank_idx
    assign bank_idx = req_addr_i[BANK_W-1:0];
  end else begin : g_bank_idx_single
    assign bank_idx = '0;
  end

  if (ROWS > 1) begin : g_row_idx
    assign row_idx = req_addr_i[ADDR_SIZE-1:ADDR_SIZE-ROW_W];
  end else begin : g_row_idx_single
    assign row_idx = '0;
  end

  assign init_done_o = init_done_q;
  assign req_ready_o = init_done_q & ~reinit_i;
  assign req_acc     = req_valid_i & req_ready_o;
  assign wr_acc      = req_acc & req_we_i;
  assign rd_acc      = req_acc & ~req_we_i;
  assign in_init     = (state_q == ST_INIT);

  // Init sweeps every row of all banks at once; otherwise the request drives the array
  always_comb begin
    mem_row   = in_init ? cnt_q : row_idx;
    mem_wdata = in_init ? INIT_VALUE : req_wdata_i;
    mem_wbe   = in_init ? {NBYTES{1'b1}} : req_wbe_i;
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [DATA_SIZE-1:0] mem [ROWS];
    logic                 bank_cs;

    assign bank_cs       = in_init | (wr_acc & (bank_idx == BANK_W'(b)));
    assign bank_rdata[b] = mem[row_idx];

    // Byte-masked write into the selected bank; contents are intentionally not reset
    always_ff @(posedge clk) begin
      if (bank_cs) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (mem_wbe[i]) mem[mem_row][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign rd_word = bank_rdata[bank_idx];

  // Next-state logic for the init sequencer and the first read response stage
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        if (reinit_i) begin
          cnt_d = '0;
        end else if (cnt_q == ROW_W'(ROWS - 1)) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + ROW_W'(1);
        end
      end
      ST_READY: begin
        if (reinit_i) begin
          state_d     = ST_INIT;
          init_done_d = 1'b0;
          cnt_d       = '0;
        end
      end
      default: begin
        state_d     = ST_INIT;
        init_done_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
    rsp_valid_d = rd_acc;
    rsp_rdata_d = rd_acc ? rd_word : rsp_rdata_q;
  end

  // Sequencer and first response stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef HPDCACHE_SRAM_OUTREG_EN
  logic                 rsp2_valid_q, rsp2_valid_d;
  logic [DATA_SIZE-1:0] rsp2_rdata_q, rsp2_rdata_d;

  // Output stage only captures data when a response moves through it
  always_comb begin
    rsp2_valid_d = rsp_valid_q;
    rsp2_rdata_d = rsp_valid_q ? rsp_rdata_q : rsp2_rdata_q;
  end

  // Extra output register stage, flushed by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp2_valid_q <= 1'b0;
      rsp2_rdata_q <= '0;
    end else begin
      rsp2_valid_q <= rsp2_valid_d;
      rsp2_rdata_q <= rsp2_rdata_d;
    end
  end

  assign rsp_valid_o = rsp2_valid_q;
  assign rsp_rdata_o = rsp2_rdata_q;
`else
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
`endif

endmodule

// File: tb/tb_hpdcache_sram_wbyteenable_banked_1rw.sv
// tb/tb_hpdcache_sram_wbyteenable_banked_1rw.sv - self-checking bench for the banked byte-enable SRAM
module tb_hpdcache_sram_wbyteenable_banked_1rw;

`ifdef HPDCACHE_SRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        reinit_i;
  logic        init_done_o;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [5:0]  req_addr_i;
  logic [63:0] req_wdata_i;
  logic [7:0]  req_wbe_i;
  logic        rsp_valid_o;
  logic [63:0] rsp_rdata_o;

  hpdcache_sram_wbyteenable_banked_1rw dut (
    .clk         (clk),
    .rst         (rst),
    .reinit_i    (reinit_i),
    .init_done_o (init_done_o),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_wbe_i   (req_wbe_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [63:0] data;
  } rsp_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [63:0] model [64];
  rsp_t        exp_q [$];
  logic [63:0] last_exp = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model[i] = '0;
  endtask

  // Drive one request from a negedge; decide acceptance just before the edge and update the model
  task automatic drive(input logic we, input logic [5:0] a, input logic [63:0] d,
                       input logic [7:0] be, output logic acc);
    rsp_t r;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = a;
    req_wdata_i = d;
    req_wbe_i   = be;
    #4;
    acc = req_ready_o;
    if (acc) begin
      if (we) begin
        for (int i = 0; i < 8; i++)
          if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
      end else begin
        r.due  = cyc + LAT;
        r.data = model[a];
        exp_q.push_back(r);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (init_done_o) break;
    end
    check(tag, 64'(n), 64'd16);
    @(negedge clk);
    check({tag, "_ready"}, 64'(req_ready_o), 64'd1);
  endtask

  task automatic read_all(input string tag);
    logic acc;
    for (int a = 0; a < 64; a++) begin
      drive(1'b0, 6'(a), 64'h0, 8'h0, acc);
      check(tag, 64'(acc), 64'd1);
    end
    idle(LAT + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"},  64'(init_done_o), 64'd0);
    check({tag, "_ready"}, 64'(req_ready_o), 64'd0);
    check({tag, "_valid"}, 64'(rsp_valid_o), 64'd0);
    check({tag, "_rdata"}, rsp_rdata_o, 64'd0);
  endtask

  always @(posedge clk) cyc++;

  // Response monitor: every cycle the expected valid/data come from the queue of accepted reads
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_exp = '0;
      check("mon_rst_valid", 64'(rsp_valid_o), 64'd0);
      check("mon_rst_rdata", rsp_rdata_o, 64'd0);
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check("mon_rsp_valid", 64'(rsp_valid_o), 64'd1);
      check("mon_rsp_rdata", rsp_rdata_o, exp_q[0].data);
      last_exp = exp_q[0].data;
      void'(exp_q.pop_front());
    end else begin
      check("mon_idle_valid", 64'(rsp_valid_o), 64'd0);
      check("mon_hold_rdata", rsp_rdata_o, last_exp);
    end
  end

  initial begin
    logic        acc;
    logic        we;
    logic [5:0]  a;
    logic [63:0] d;
    logic [7:0]  be;

    rst         = 1'b1;
    reinit_i    = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_wbe_i   = '0;
    model_clear();

    // reset state and first init
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    #2 rst = 1'b0;
    wait_init("init_cycles");
    read_all("init_read_acc");

    // byte-enable merge
    drive(1'b1, 6'd5, 64'h1122334455667788, 8'hFF, acc);
    check("wr5_acc", 64'(acc), 64'd1);
    drive(1'b1, 6'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F, acc);
    drive(1'b0, 6'd5, 64'h0, 8'h0, acc);
    req_valid_i = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check("rd5_valid", 64'(rsp_valid_o), 64'd1);
    check("rd5_data", rsp_rdata_o, 64'h11223344AAAAAAAA);
    idle(2);

    // back-to-back reads across all banks, then same bank
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 6'(i), {$urandom, $urandom}, 8'hFF, acc);
    end
    drive(1'b0, 6'd0, 64'h0, 8'h0, acc);
    drive(1'b0, 6'd1, 64'h0, 8'h0, acc);
    drive(1'b0, 6'd2, 64'h0, 8'h0, acc);
    drive(1'b0, 6'd3, 64'h0, 8'h0, acc);
    drive(1'b0, 6'd4, 64'h0, 8'h0, acc);
    drive(1'b0, 6'd8, 64'h0, 8'h0, acc);
    check("b2b_acc", 64'(acc), 64'd1);
    idle(LAT + 1);

    // read-after-write and wbe=0 no-op
    drive(1'b1, 6'd9, 64'hDEADBEEFCAFEF00D, 8'hFF, acc);
    drive(1'b0, 6'd9, 64'h0, 8'h0, acc);
    drive(1'b1, 6'd9, 64'h0123456789ABCDEF, 8'h00, acc);
    drive(1'b0, 6'd9, 64'h0, 8'h0, acc);
    req_valid_i = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check("raw9_nop", rsp_rdata_o, 64'hDEADBEEFCAFEF00D);
    idle(2);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        we = 1'($urandom_range(0, 1));
        a  = 6'($urandom_range(0, 63));
        d  = {$urandom, $urandom};
        be = 8'($urandom);
        drive(we, a, d, be, acc);
        check("rand_acc", 64'(acc), 64'd1);
      end
    end
    idle(LAT + 1);

    // reinit with a read pending and a request colliding with reinit
    drive(1'b0, 6'd9, 64'h0, 8'h0, acc);
    reinit_i = 1'b1;
    drive(1'b0, 6'd10, 64'h0, 8'h0, acc);
    check("reinit_not_acc", 64'(acc), 64'd0);
    reinit_i    = 1'b0;
    req_valid_i = 1'b0;
    model_clear();
    wait_init("reinit_cycles");
    read_all("reinit_read_acc");

    // reinit pulse in the middle of init restarts the sweep
    reinit_i = 1'b1;
    @(negedge clk);
    reinit_i = 1'b0;
    repeat (5) @(negedge clk);
    reinit_i = 1'b1;
    @(negedge clk);
    reinit_i = 1'b0;
    wait_init("reinit_in_init_cycles");

    // reset with nonzero held read data, then reset in the middle of init
    drive(1'b1, 6'd3, 64'hFEDCBA9876543210, 8'hFF, acc);
    drive(1'b0, 6'd3, 64'h0, 8'h0, acc);
    idle(LAT + 1);
    check("pre_rst_rdata", rsp_rdata_o, 64'hFEDCBA9876543210);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_ready");
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid_init");
    model_clear();
    @(negedge clk);
    #2 rst = 1'b0;
    wait_init("rst_mid_init_cycles");
    read_all("rst_read_acc");

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
